// File: rtl/ray_stream_if.sv
// Ray-link stream bundle: upstream packed-ray handshake plus downstream
// 24-bit word stream with last marker.
interface ray_stream_if #(
  parameter int WORD_W = 24
);
  logic                  in_valid;
  logic [6*WORD_W-1:0]   in_ray;
  logic                  in_ready;
  logic                  out_valid;
  logic [WORD_W-1:0]     out_data;
  logic                  out_last;
  logic                  out_ready;

  // Producer of rays and consumer of words (camera side + link side).
  modport master (
    output in_valid, in_ray, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  // The serialiser itself.
  modport slave (
    input  in_valid, in_ray, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/ray_stream_tx.sv
// Transmit end of the ray word-stream link. Latches one 144-bit ray
// (orig x,y,z then dir x,y,z, signed 24-bit fields) and emits it as six
// words, orig.x first, with out_last on dir.z. A new ray can be taken on
// the final word handshake so sustained traffic has no bubbles.
module ray_stream_tx #(
  parameter int CNT_W  = 16,
  parameter int WORD_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  ray_stream_if.slave      rs,
  output logic             busy,
  output logic [CNT_W-1:0] ray_count
);

  localparam int RAY_W = 6 * WORD_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [RAY_W-1:0]     hold_r;
  logic [2:0]           idx_r;
  logic [2:0]           idx_nxt_s;
  logic                 ready_q_r;
  logic [WORD_W-1:0]    out_data_r;
  logic                 out_last_r;
  logic [CNT_W-1:0]     count_r;
  logic                 out_fire_s;
  logic                 last_fire_s;
  logic                 in_ready_s;
  logic                 in_fire_s;

  // Field select in wire order: index 0 is the MSB field (orig.x).
  function automatic logic [WORD_W-1:0] word_sel(input logic [RAY_W-1:0] r,
                                                 input logic [2:0]       i);
    case (i)
      3'd0:    word_sel = r[RAY_W-1          -: WORD_W];
      3'd1:    word_sel = r[RAY_W-1-WORD_W   -: WORD_W];
      3'd2:    word_sel = r[RAY_W-1-2*WORD_W -: WORD_W];
      3'd3:    word_sel = r[RAY_W-1-3*WORD_W -: WORD_W];
      3'd4:    word_sel = r[RAY_W-1-4*WORD_W -: WORD_W];
      3'd5:    word_sel = r[RAY_W-1-5*WORD_W -: WORD_W];
      default: word_sel = {WORD_W{1'b0}};
    endcase
  endfunction

  // Handshake decode; in_ready may follow out_ready combinationally on the last word.
  always_comb begin
    idx_nxt_s   = idx_r + 3'd1;
    out_fire_s  = (state_r == SEND) && rs.out_ready;
    last_fire_s = out_fire_s && (idx_r == 3'd5);
    in_ready_s  = ready_q_r && ((state_r == IDLE) || last_fire_s);
    in_fire_s   = rs.in_valid && in_ready_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: stay in SEND across rays when a new one is taken on the last word.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_fire_s) begin
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (last_fire_s && !in_fire_s) begin
          state_s = IDLE;
        end else begin
          state_s = SEND;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode: valid/busy come straight from the state flop, data/last from their flops.
  always_comb begin
    rs.out_valid = (state_r == SEND);
    busy         = (state_r == SEND);
    rs.in_ready  = in_ready_s;
    rs.out_data  = out_data_r;
    rs.out_last  = out_last_r;
    ray_count    = count_r;
  end

  // Keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q_r <= 1'b0;
    end else begin
      ready_q_r <= 1'b1;
    end
  end

  // Holding register, word index and registered word/last outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r     <= {RAY_W{1'b0}};
      idx_r      <= 3'd0;
      out_data_r <= {WORD_W{1'b0}};
      out_last_r <= 1'b0;
    end else if (in_fire_s) begin
      hold_r     <= rs.in_ray;
      idx_r      <= 3'd0;
      out_data_r <= word_sel(rs.in_ray, 3'd0);
      out_last_r <= 1'b0;
    end else if (out_fire_s && (idx_r != 3'd5)) begin
      idx_r      <= idx_nxt_s;
      out_data_r <= word_sel(hold_r, idx_nxt_s);
      out_last_r <= (idx_nxt_s == 3'd5);
    end else begin
      hold_r     <= hold_r;
      idx_r      <= idx_r;
      out_data_r <= out_data_r;
      out_last_r <= out_last_r;
    end
  end

  // Sent-ray counter, bumped on each last-word handshake; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
    end else if (last_fire_s) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule
